uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Serial UART receiver with a show-ahead receive FIFO. It feeds the core's uart_in, uart_empty and uart_rdreq interface.
- Deserialises 8N1 frames from the rxd pin and pushes each byte into the FIFO.
- The core pops bytes with a one-cycle read strobe.
- Sits between the board RX pin and the CPU top's memory-mapped UART read port.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per bit (50 MHz / 115200). Must be >= 4.
- DEPTH_LOG2, 4: FIFO holds 2**DEPTH_LOG2 bytes.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- rxd, input, 1: asynchronous serial input; idles high.
- rdreq, input, 1: pop strobe from the core. Ignored while empty=1.
- q, output, 8: head-of-FIFO byte. Valid while empty=0; forced to 8'h00 while empty=1.
- empty, output, 1: FIFO holds no bytes.
- full, output, 1: FIFO holds 2**DEPTH_LOG2 bytes.
- count, output, DEPTH_LOG2+1: current occupancy.
- frame_err, output, 1: sticky; a stop bit was sampled low.
- overrun, output, 1: sticky; a byte was dropped because the FIFO was full.
- err_clr, input, 1: synchronous clear of frame_err, overrun (and parity_err).

Behaviour:
- Reset (async assert; release takes effect on the next clk edge):
  - FSM to IDLE; pointers and count = 0.
  - empty=1, full=0, q=8'h00, frame_err=0, overrun=0.
  - Synchroniser flops preset to 1.
  - Reset mid-frame abandons the frame with no push.
- rxd passes through a 2-flop synchroniser (rxs). Receiver latency from a pin edge is 2 cycles.
- Baud counter: CLKS_PER_BIT-1 down to 0; reloads on each sample point.
- FSM states:
  - IDLE: on rxs=0, go to START and load counter with CLKS_PER_BIT/2 - 1.
  - START: at counter 0, sample rxs.
    - rxs=1: false start, back to IDLE.
    - rxs=0: go to DATA with bit index 0.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxs=1: push byte, go to IDLE.
    - rxs=0: set frame_err, no push, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then IDLE. A break condition produces no bytes.
- Push occurs on the cycle the stop bit is sampled. The byte is visible on q and empty falls on the following cycle.
- FIFO ordering and pointers:
  - Show-ahead; q = mem[rd_ptr] (masked to 0 when empty).
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth. count is the separate occupancy counter.
- Pop: rdreq=1 with empty=0 advances rd_ptr at the edge; the next byte is on q the following cycle.
- Push while full:
  - Without a same-cycle pop: byte dropped, overrun set.
  - With a same-cycle pop: both occur, count unchanged, no overrun.
- Push and rdreq while empty: rdreq ignored; after the edge count=1.
- err_clr and a same-cycle error event: the set wins.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state between DATA and STOP samples one extra bit.
  - Mismatch with even parity of the data bits sets sticky output parity_err (1 bit) and the byte is discarded. The stop bit is still checked.
  - parity_err resets to 0 and is cleared by err_clr.
- Undefined: 8N1 only; parity_err port and the PARITY state do not exist.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - Constant DATA_BITS=8.
  - Default CLKS_PER_BIT.
- One natural sub-module: sync_fifo (parameterised DEPTH_LOG2, WIDTH=8, show-ahead, count/full/empty). It is instantiated once; the deserialiser FSM stays in the top.

Test Plan:
1. CLKS_PER_BIT=16. Send 8'hA5 (8N1). At the stop-bit sample cycle +1: empty=0, q=8'hA5, count=1. Pulse rdreq: empty=1, q=8'h00 next cycle.
2. Send 8'h01, 8'h80, 8'hFF back-to-back with no pops. Pop each: q reads 01, 80, FF in order; count steps 3->2->1->0; no error flags.
3. DEPTH_LOG2=2. Send 5 bytes 8'h10..8'h14 with no pops: full=1, count=4, overrun=1, FIFO holds 10..13. Repeat with rdreq asserted on the 5th push cycle: overrun stays 0, count=4.
4. rxd low for 6 cycles then high (glitch < half bit): no push, FSM returns to IDLE. Then send a frame with a low stop bit: frame_err=1, empty=1. Hold rxd low 40 cycles: no bytes pushed. Pulse err_clr: frame_err=0.
5. Assert rst during bit 4 of a frame: all outputs at reset values immediately. Release, then send 8'h3C: received correctly.
6. UART_RX_PARITY_EN defined: 8'h07 with parity 1 is accepted. 8'h07 with parity 0 sets parity_err=1, empty stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
// The optional 8E1 frame format is selected with UART_RX_PARITY_EN.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head word is always presented on o_q (zero when empty).
// A write while full is only accepted if a read is accepted on the same edge.
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr,
    input  logic [WIDTH-1:0]      i_din,
    input  logic                  i_rd,
    output logic [WIDTH-1:0]      o_q,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_rd_acc;
    logic                  w_wr_acc;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == (DEPTH_LOG2+1)'(DEPTH));
    assign o_count  = r_count;
    assign o_q      = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_rd_acc = i_rd && !o_empty;
    assign w_wr_acc = i_wr && (!o_full || w_rd_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale words are hidden by the empty mask on o_q.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a show-ahead FIFO.
// dbg_state exposes the deserialiser FSM state.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rxd,
    input  logic                rdreq,
    output logic [7:0]          q,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] count,
    output logic                frame_err,
    output logic                overrun,
`ifdef UART_RX_PARITY_EN
    output logic                parity_err,
`endif
    input  logic                err_clr,
    output state_t              dbg_state
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] FULL_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_RELOAD = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [BW-1:0]        r_baud;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_rxs;
    logic                 w_tick;
    logic                 w_stop_tick;
    logic                 w_push;
    logic                 w_frame_set;
    logic                 w_overrun_set;
    logic                 w_par_bad;

    assign w_rxs       = r_sync2;
    assign w_tick      = (r_baud == '0);
    assign w_stop_tick = (r_state == STOP) && w_tick;
    assign w_frame_set = w_stop_tick && !w_rxs;

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    logic w_par_set;
    // Even parity: the parity bit equals the XOR of the data bits.
    assign w_par_set  = (r_state == PARITY) && w_tick && (w_rxs != ^r_shift);
    assign w_par_bad  = r_par_bad;
    assign parity_err = r_parity_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == PARITY && w_tick) r_par_bad <= (w_rxs != ^r_shift);
            if (w_par_set)                   r_parity_err <= 1'b1;
            else if (err_clr)                r_parity_err <= 1'b0;
        end
    end
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_push        = w_stop_tick && w_rxs && !w_par_bad;
    assign w_overrun_set = w_push && full && !rdreq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_baud  <= HALF_RELOAD;
                    end
                end
                START: begin
                    if (!w_tick) begin
                        r_baud <= r_baud - 1'b1;
                    end else if (w_rxs) begin
                        r_state <= IDLE;
                    end else begin
                        r_state   <= DATA;
                        r_bit_idx <= '0;
                        r_baud    <= FULL_RELOAD;
                    end
                end
                DATA: begin
                    if (!w_tick) begin
                        r_baud <= r_baud - 1'b1;
                    end else begin
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        r_baud  <= FULL_RELOAD;
                        if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (!w_tick) begin
                        r_baud <= r_baud - 1'b1;
                    end else begin
                        r_state <= STOP;
                        r_baud  <= FULL_RELOAD;
                    end
                end
`endif
                STOP: begin
                    if (!w_tick) r_baud <= r_baud - 1'b1;
                    else         r_state <= w_rxs ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (w_rxs) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Error flags are sticky; a same-cycle set beats err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_frame_set)   r_frame_err <= 1'b1;
            else if (err_clr)  r_frame_err <= 1'b0;
            if (w_overrun_set) r_overrun <= 1'b1;
            else if (err_clr)  r_overrun <= 1'b0;
        end
    end

    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_push),
        .i_din   (r_shift),
        .i_rd    (rdreq),
        .o_q     (q),
        .o_empty (empty),
        .o_full  (full),
        .o_count (count)
    );

endmodule
